reg_dump_tx: RTL and testbench
==============================

Name: reg_dump_tx

Overview:
- Hardware counterpart of the simulation register-dump flow for the single-cycle CPU.
- Sits beside sccomp and drives the CPU's debug read port (reg_sel/reg_data).
- On a dump request or a PC breakpoint match, it stalls the CPU and snapshots the PC. It then walks all registers and transmits one framed byte stream over a valid/ready byte interface (feeds the UART TX path).

Parameters:
- NUM_REGS, 32, number of registers dumped (1..32), starting at index 0
- HDR_BYTE, 8'hA5, frame start byte

Ports:
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- dump_req  in  1  single-cycle dump request pulse
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- pc  in  32  current CPU PC
- reg_sel  out  5  register index to CPU debug port
- reg_data  in  32  combinational register value for reg_sel
- cpu_stall  out  1  freezes CPU PC/regfile writes while high
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after checksum byte accepted

Behaviour:
- Reset (async, rstn=0): state IDLE; tx_valid=0, tx_data=0, reg_sel=0, cpu_stall=0, busy=0, done=0, checksum=0, bp_match_q=0. Any frame in flight is abandoned and tx_valid drops immediately. No resume after reset release.
- Trigger: trig = dump_req | (bp_en & (pc==bp_addr) & ~bp_match_q). bp_match_q is the registered match, so the breakpoint fires once per arrival, not every cycle while the CPU sits at bp_addr.
- Triggers while busy are ignored and not queued.
- In IDLE, when trig is high at edge k:
  - pc is latched into pc_snap.
  - The state moves to HDR.
  - cpu_stall=1, busy=1, tx_valid=1 and tx_data=HDR_BYTE are all registered outputs valid after edge k.
- States: IDLE -> HDR -> PC0..PC3 -> SEL -> RB0..RB3 -> (SEL, or CSUM after the last register) -> IDLE.
- Handshake:
  - A byte transfers on an edge with tx_valid & tx_ready.
  - tx_data must stay stable while tx_valid & ~tx_ready.
  - Byte-sending states advance only on a transfer.
  - tx_valid may be held high for any number of cycles.
- PC0..PC3 send pc_snap big-endian: [31:24] first.
- SEL:
  - One cycle with tx_valid=0. reg_sel already holds the current index.
  - At the end of SEL, reg_data is captured into a 32-bit shift register.
  - reg_sel changes only on entry to SEL, never while a register's bytes are being sent.
- RB0..RB3 send the captured word big-endian.
- After RB3 of index NUM_REGS-1, go to CSUM; otherwise reg_sel increments and the state returns to SEL.
- Register 0 is sent exactly as reg_data returns it, with no forcing to 0.
- Checksum:
  - 8-bit XOR of every byte after the header (PC and register bytes).
  - Cleared on trigger; updated on each transfer.
  - The CSUM state sends it.
- On the CSUM transfer: state IDLE, tx_valid=0, cpu_stall=0, busy=0, reg_sel=0, and done=1 for exactly one cycle.
- Frame length: 1+4+4*NUM_REGS+1 bytes (134 for default).
- Minimum duration with tx_ready tied high: 1+4+5*NUM_REGS+1 cycles (166 for default).
- cpu_stall is high from the edge after trigger through the edge of the CSUM transfer inclusive.
- Simultaneous events:
  - dump_req and a breakpoint match in the same cycle produce one frame.
  - A trigger in the same cycle as done (state already IDLE) is accepted; done and the new HDR start coincide.

Test Plan:
- Preload rf[i]=32'h11111111*i mod 2^32 (i=1..31), pc=32'h00000048, tx_ready=1, pulse dump_req -> 134 bytes: A5 00 00 00 48, 00 00 00 00, 11 11 11 11, 22 22 22 22, ..., correct XOR checksum byte; done 166 cycles after trigger; cpu_stall high throughout.
- Same frame with tx_ready randomly toggled (50%) -> identical byte sequence; tx_data never changes while tx_valid & ~tx_ready; reg_sel constant during each register's 4 bytes.
- bp_en=1, bp_addr=32'h0000001C, CPU runs program and stalls at 0x1C -> exactly one frame with PC bytes 00 00 00 1C; no second frame while pc stays 0x1C; second frame after pc leaves and returns.
- dump_req pulsed repeatedly while busy -> still exactly one frame; pulse on the done cycle -> second frame starts immediately.
- rstn low after byte 40 -> tx_valid, cpu_stall, busy, reg_sel drop asynchronously (before the next clock edge); after release, no bytes until a new trigger; new frame complete and correct.
- NUM_REGS=4 build, tx_ready=1 -> 22-byte frame, done after 26 cycles, reg_sel visits 0..3 only.

Source files
------------

// File: rtl/reg_dump_tx_if.sv
// rtl/reg_dump_tx_if.sv - byte stream from the dump transmitter to the UART TX path
//   tx_data  : byte presented to the transmitter
//   tx_valid : tx_data is valid
//   tx_ready : transmitter accepts the byte on this edge
//   master   : drives tx_data/tx_valid (reg_dump_tx)
//   slave    : drives tx_ready (transmitter)
interface reg_dump_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - stalls the CPU and streams a framed PC/register dump
//   clk       : system clock
//   rstn      : asynchronous active-low reset
//   dump_req  : single-cycle dump request
//   bp_en     : breakpoint enable
//   bp_addr   : breakpoint PC
//   pc        : current CPU PC
//   reg_sel   : register index to the CPU debug read port
//   reg_data  : combinational register value for reg_sel
//   cpu_stall : freezes CPU PC/regfile writes
//   tx        : byte stream (master side)
//   busy      : frame in progress
//   done      : one-cycle pulse after the checksum byte is accepted
// Frame: HDR_BYTE, PC[31:24..7:0], reg[0..NUM_REGS-1] big-endian, XOR checksum.
module reg_dump_tx #(
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 dump_req,
  input  logic                 bp_en,
  input  logic [31:0]          bp_addr,
  input  logic [31:0]          pc,
  output logic [4:0]           reg_sel,
  input  logic [31:0]          reg_data,
  output logic                 cpu_stall,
  reg_dump_tx_if.master        tx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [4:0] LAST_SEL = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PC,
    S_SEL,
    S_RB,
    S_CSUM
  } state_e;

  state_e      state_q;
  logic [31:0] shift_q;      // holds pc_snap, later the captured register word
  logic [1:0]  cnt_q;        // byte index within the current 32-bit word
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic [7:0]  csum_q;
  logic [4:0]  reg_sel_q;
  logic        stall_q;
  logic        busy_q;
  logic        done_q;
  logic        bp_match_q;

  logic        bp_hit;
  logic        trig;
  logic        xfer;
  logic [7:0]  csum_d;

  assign bp_hit = bp_en && (pc == bp_addr);
  // Edge-detect the match so a CPU parked on bp_addr yields a single frame.
  assign trig   = dump_req | (bp_hit & ~bp_match_q);
  assign xfer   = tx_valid_q & tx.tx_ready;
  assign csum_d = csum_q ^ tx_data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      csum_q     <= '0;
      reg_sel_q  <= '0;
      stall_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bp_match_q <= 1'b0;
    end else begin
      bp_match_q <= bp_hit;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trig) begin
            state_q    <= S_HDR;
            shift_q    <= pc;
            csum_q     <= '0;
            tx_data_q  <= HDR_BYTE;
            tx_valid_q <= 1'b1;
            stall_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_HDR: begin
          // Header is not part of the checksum.
          if (xfer) begin
            state_q   <= S_PC;
            tx_data_q <= shift_q[31:24];
            shift_q   <= {shift_q[23:0], 8'h00};
            cnt_q     <= 2'd0;
          end
        end
        S_PC: begin
          if (xfer) begin
            csum_q <= csum_d;
            if (cnt_q == 2'd3) begin
              state_q    <= S_SEL;
              tx_valid_q <= 1'b0;
            end else begin
              tx_data_q <= shift_q[31:24];
              shift_q   <= {shift_q[23:0], 8'h00};
              cnt_q     <= cnt_q + 2'd1;
            end
          end
        end
        S_SEL: begin
          // reg_sel has been stable for this whole cycle; sample the word now.
          state_q    <= S_RB;
          tx_data_q  <= reg_data[31:24];
          shift_q    <= {reg_data[23:0], 8'h00};
          tx_valid_q <= 1'b1;
          cnt_q      <= 2'd0;
        end
        S_RB: begin
          if (xfer) begin
            csum_q <= csum_d;
            if (cnt_q == 2'd3) begin
              if (reg_sel_q == LAST_SEL) begin
                state_q   <= S_CSUM;
                tx_data_q <= csum_d;
              end else begin
                state_q    <= S_SEL;
                reg_sel_q  <= reg_sel_q + 5'd1;
                tx_valid_q <= 1'b0;
              end
            end else begin
              tx_data_q <= shift_q[31:24];
              shift_q   <= {shift_q[23:0], 8'h00};
              cnt_q     <= cnt_q + 2'd1;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            stall_q    <= 1'b0;
            busy_q     <= 1'b0;
            reg_sel_q  <= '0;
            done_q     <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign reg_sel     = reg_sel_q;
  assign cpu_stall   = stall_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb/tb_reg_dump_tx.sv - randomized self-checking bench for reg_dump_tx
module tb_reg_dump_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        dump_req0, dump_req1;
  logic        bp_en, bp_en1;
  logic [31:0] bp_addr, pc;
  logic [4:0]  reg_sel0, reg_sel1;
  logic [31:0] reg_data0, reg_data1;
  logic        stall0, stall1, busy0, busy1, done0, done1;
  logic [31:0] rf [32];

  assign reg_data0 = rf[reg_sel0];
  assign reg_data1 = rf[reg_sel1];

  reg_dump_tx_if if0 ();
  reg_dump_tx_if if1 ();

  reg_dump_tx #(.NUM_REGS(32), .HDR_BYTE(8'hA5)) dut0 (
    .clk(clk), .rstn(rstn), .dump_req(dump_req0), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .reg_sel(reg_sel0), .reg_data(reg_data0), .cpu_stall(stall0), .tx(if0),
    .busy(busy0), .done(done0)
  );

  reg_dump_tx #(.NUM_REGS(4), .HDR_BYTE(8'hA5)) dut1 (
    .clk(clk), .rstn(rstn), .dump_req(dump_req1), .bp_en(bp_en1), .bp_addr(bp_addr),
    .pc(pc), .reg_sel(reg_sel1), .reg_data(reg_data1), .cpu_stall(stall1), .tx(if1),
    .busy(busy1), .done(done1)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   rnd_ready = 1'b0;
  int   max_sel1 = 0;

  logic [7:0] cap0[$], cap1[$], exp_q[$];
  logic [4:0] sel0q[$], sel1q[$];
  logic       st0q[$], st1q[$];

  logic       pend0 = 1'b0, pend1 = 1'b0;
  logic [7:0] pdat0, pdat1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if0.tx_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
  end

  // Transfer capture and hold-stability checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn && pend0) begin
      check("hold_valid0", 32'(if0.tx_valid), 32'd1);
      check("hold_data0", 32'(if0.tx_data), 32'(pdat0));
    end
    if (rstn && pend1) begin
      check("hold_valid1", 32'(if1.tx_valid), 32'd1);
      check("hold_data1", 32'(if1.tx_data), 32'(pdat1));
    end
    pend0 = rstn && if0.tx_valid && !if0.tx_ready;
    pdat0 = if0.tx_data;
    pend1 = rstn && if1.tx_valid && !if1.tx_ready;
    pdat1 = if1.tx_data;
    if (rstn && if0.tx_valid && if0.tx_ready) begin
      cap0.push_back(if0.tx_data);
      sel0q.push_back(reg_sel0);
      st0q.push_back(stall0);
    end
    if (rstn && if1.tx_valid && if1.tx_ready) begin
      cap1.push_back(if1.tx_data);
      sel1q.push_back(reg_sel1);
      st1q.push_back(stall1);
    end
    if (rstn && int'(reg_sel1) > max_sel1) max_sel1 = int'(reg_sel1);
  end

  // Reference frame: header, PC word, registers 0..n-1, XOR of all but the header.
  task automatic build_exp(input logic [31:0] p, input int n);
    logic [31:0] w;
    logic [7:0]  x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    x = 8'h00;
    for (int i = -1; i < n; i++) begin
      if (i < 0) w = p;
      else       w = rf[i];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[8*b +: 8]);
        x ^= w[8*b +: 8];
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic cmp_frame(input string tag, input logic [7:0] got[$], input logic [4:0] sels[$],
                           input logic sts[$], input logic [31:0] p, input int n);
    int unstalled;
    build_exp(p, n);
    unstalled = 0;
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
      if (i >= 5 && i < 5 + 4 * n)
        check($sformatf("%s_sel%0d", tag, i), 32'(sels[i]), 32'((i - 5) / 4));
      if (!sts[i]) unstalled++;
    end
    check({tag, "_stall"}, 32'(unstalled), 32'd0);
  endtask

  task automatic clear_caps();
    cap0.delete(); sel0q.delete(); st0q.delete();
    cap1.delete(); sel1q.delete(); st1q.delete();
  endtask

  // Pulse dump_req for the edge following the call; returns that edge's number.
  task automatic fire_now(input int d, output int tcyc);
    if (d == 0) dump_req0 = 1'b1;
    else        dump_req1 = 1'b1;
    tcyc = cyc + 1;
    @(posedge clk);
    #1;
    dump_req0 = 1'b0;
    dump_req1 = 1'b0;
  endtask

  task automatic wait_done(input int d, input bit spam, output int dcyc);
    logic dn;
    dcyc = -1;
    dn = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      dump_req0 = 1'b0;
      dn = (d == 0) ? done0 : done1;
      if (dn) begin
        dcyc = cyc;
        break;
      end
      if (spam && busy0 && ($urandom % 4 == 0)) dump_req0 = 1'b1;
    end
    if (dcyc < 0) check($sformatf("done_timeout%0d", d), 32'(dn), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int t, dc, k;
  logic [31:0] pcr;

  initial begin
    rstn = 1'b0;
    dump_req0 = 1'b0; dump_req1 = 1'b0;
    bp_en = 1'b0; bp_en1 = 1'b0; bp_addr = 32'h0; pc = 32'h48;
    if0.tx_ready = 1'b1; if1.tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'h11111111 * i;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(if0.tx_valid), 32'd0);
    check("rst_data", 32'(if0.tx_data), 32'd0);
    check("rst_sel", 32'(reg_sel0), 32'd0);
    check("rst_stall", 32'(stall0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_valid1", 32'(if1.tx_valid), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // A: known pattern, ready tied high.
    clear_caps();
    fire_now(0, t);
    check("A_stall_on", 32'(stall0), 32'd1);
    check("A_hdr_valid", 32'(if0.tx_valid), 32'd1);
    wait_done(0, 0, dc);
    check("A_latency", 32'(dc - t), 32'd166);
    cmp_frame("A", cap0, sel0q, st0q, 32'h48, 32);
    check("A_busy_off", 32'(busy0), 32'd0);
    check("A_stall_off", 32'(stall0), 32'd0);
    clear_caps();

    // B: same frame under random backpressure.
    rnd_ready = 1'b1;
    @(posedge clk); #1;
    fire_now(0, t);
    wait_done(0, 0, dc);
    cmp_frame("B", cap0, sel0q, st0q, 32'h48, 32);
    clear_caps();

    // C: random data, triggers spammed while busy.
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    pc = $urandom;
    pcr = pc;
    @(posedge clk); #1;
    fire_now(0, t);
    wait_done(0, 1, dc);
    cmp_frame("C", cap0, sel0q, st0q, pcr, 32);
    clear_caps();
    repeat (30) @(posedge clk);
    #1;
    check("C_extra_bytes", 32'(cap0.size()), 32'd0);
    check("C_extra_busy", 32'(busy0), 32'd0);

    // D: trigger in the done cycle starts the next frame immediately.
    rnd_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    @(posedge clk); #1;
    fire_now(0, t);
    wait_done(0, 0, dc);
    cmp_frame("D1", cap0, sel0q, st0q, pcr, 32);
    clear_caps();
    fire_now(0, t);
    check("D2_busy", 32'(busy0), 32'd1);
    check("D2_hdr", 32'(if0.tx_data), 32'hA5);
    wait_done(0, 0, dc);
    check("D2_latency", 32'(dc - t), 32'd166);
    cmp_frame("D2", cap0, sel0q, st0q, pcr, 32);
    clear_caps();

    // BP: breakpoint fires once per arrival at bp_addr.
    bp_addr = 32'h1C;
    bp_en = 1'b1;
    pc = 32'h10;
    @(posedge clk); #1; pc = 32'h14;
    @(posedge clk); #1; pc = 32'h18;
    @(posedge clk); #1; pc = 32'h1C;
    t = cyc + 1;
    wait_done(0, 0, dc);
    check("BP1_latency", 32'(dc - t), 32'd166);
    cmp_frame("BP1", cap0, sel0q, st0q, 32'h1C, 32);
    clear_caps();
    repeat (200) @(posedge clk);
    #1;
    check("BP_parked_bytes", 32'(cap0.size()), 32'd0);
    check("BP_parked_busy", 32'(busy0), 32'd0);
    pc = 32'h20;
    repeat (2) @(posedge clk);
    #1;
    pc = 32'h1C;
    fire_now(0, t);
    wait_done(0, 0, dc);
    cmp_frame("BP2", cap0, sel0q, st0q, 32'h1C, 32);
    clear_caps();
    repeat (30) @(posedge clk);
    #1;
    check("BP2_single", 32'(cap0.size()), 32'd0);
    bp_en = 1'b0;

    // R: asynchronous reset mid-frame, then a clean frame.
    rnd_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    pc = $urandom;
    pcr = pc;
    @(posedge clk); #1;
    fire_now(0, t);
    for (k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (cap0.size() >= 40) break;
    end
    check("R_reach40", 32'(cap0.size() >= 40), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("R_valid", 32'(if0.tx_valid), 32'd0);
    check("R_stall", 32'(stall0), 32'd0);
    check("R_busy", 32'(busy0), 32'd0);
    check("R_sel", 32'(reg_sel0), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_caps();
    repeat (50) @(posedge clk);
    #1;
    check("R_quiet_bytes", 32'(cap0.size()), 32'd0);
    check("R_quiet_busy", 32'(busy0), 32'd0);
    fire_now(0, t);
    wait_done(0, 0, dc);
    cmp_frame("R", cap0, sel0q, st0q, pcr, 32);
    clear_caps();

    // N4: four-register build.
    rnd_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    @(posedge clk); #1;
    fire_now(1, t);
    wait_done(1, 0, dc);
    check("N4_latency", 32'(dc - t), 32'd26);
    cmp_frame("N4", cap1, sel1q, st1q, pcr, 4);
    check("N4_max_sel", 32'(max_sel1), 32'd3);
    clear_caps();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
